// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op encodings,
// FSM state type and width constants.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // Quotient returned for a divide by zero
    localparam logic [MD_WIDTH-1:0] MD_DIV0_Q = '1;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
//   is_div = 0 : shift-add multiply. acc upper half accumulates, the product
//                shifts right into the lower half; q holds the multiplier.
//   is_div = 1 : restoring divide. acc = remainder:quotient, q supplies the
//                dividend bits MSB first; opnd is the divisor.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0]   q_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;

    // Compute both candidate updates and select by operation type
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (q[0] ? {1'b0, opnd} : '0);
        rem_shift = {acc[2*WIDTH-1:WIDTH], q[WIDTH-1]};
        fits      = (rem_shift >= {1'b0, opnd});
        rem_sub   = rem_shift[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (fits) begin
                acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
            q_next = {q[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
            q_next   = {1'b0, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer. Captures operands, runs an iterative
// shift-add multiply or restoring divide, stalls the pipeline meanwhile and
// presents the result for one cycle. Divide-by-zero and signed overflow
// resolve directly from PREP.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle
// using a native product, going straight from IDLE to DONE.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       FUNCT3,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             STALL,
    output logic [WIDTH-1:0] RESULT,
    output logic             RESULT_VALID
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [5:0]       LAST    = 6'(WIDTH - 1);

    md_state_t          state, state_nx;
    logic [5:0]         cnt;
    logic [2:0]         op;
    logic [WIDTH-1:0]   d1, d2;
    logic [WIDTH-1:0]   q, opnd, q_nx;
    logic [2*WIDTH-1:0] acc, acc_nx, prod_fix;
    logic [WIDTH-1:0]   div_sel, div_fix, fix_val, special_val, res_nx;
    logic               neg, load_res;
    logic               is_div, is_rem, sgn1, sgn2, a_neg, b_neg, div0, ovf;
    logic [WIDTH-1:0]   abs1, abs2;

    // Operand decode on the captured op
    always_comb begin
        is_div = op[2];
        is_rem = op[2] & op[1];
        sgn1   = is_div ? ~op[0] : (op == MD_MULH || op == MD_MULHSU);
        sgn2   = is_div ? ~op[0] : (op == MD_MULH);
        a_neg  = sgn1 & d1[WIDTH-1];
        b_neg  = sgn2 & d2[WIDTH-1];
        abs1   = a_neg ? -d1 : d1;
        abs2   = b_neg ? -d2 : d2;
        div0   = is_div && (d2 == '0);
        ovf    = is_div && !op[0] && (d1 == MIN_NEG) && (d2 == '1);
        if (div0) begin
            special_val = is_rem ? d1 : MD_DIV0_Q;
        end else begin
            special_val = is_rem ? '0 : MIN_NEG;
        end
        prod_fix = neg ? -acc : acc;
        div_sel  = is_rem ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
        div_fix  = neg ? -div_sel : div_sel;
        if (is_div) begin
            fix_val = div_fix;
        end else if (op == MD_MUL) begin
            fix_val = prod_fix[WIDTH-1:0];
        end else begin
            fix_val = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic                      f_sgn1, f_sgn2;
    logic signed [2*WIDTH+1:0] fast_prod;
    logic [WIDTH-1:0]          fast_val;

    // Single-cycle signed/unsigned product straight from the live operands
    always_comb begin
        f_sgn1    = (FUNCT3 == MD_MULH) || (FUNCT3 == MD_MULHSU);
        f_sgn2    = (FUNCT3 == MD_MULH);
        fast_prod = $signed({f_sgn1 & DATA1[WIDTH-1], DATA1})
                  * $signed({f_sgn2 & DATA2[WIDTH-1], DATA2});
        fast_val  = (FUNCT3 == MD_MUL) ? fast_prod[WIDTH-1:0]
                                       : fast_prod[2*WIDTH-1:WIDTH];
    end
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .q        (q),
        .opnd     (opnd),
        .acc_next (acc_nx),
        .q_next   (q_nx)
    );

    // Next-state logic and result load selection; FLUSH overrides sequencing
    always_comb begin
        state_nx = state;
        load_res = 1'b0;
        res_nx   = '0;
        case (state)
            MD_IDLE: begin
                if (START) begin
`ifdef MULDIV_FAST_MUL_EN
                    if (!FUNCT3[2]) begin
                        state_nx = MD_DONE;
                        load_res = 1'b1;
                        res_nx   = fast_val;
                    end else begin
                        state_nx = MD_PREP;
                    end
`else
                    state_nx = MD_PREP;
`endif
                end
            end
            MD_PREP: begin
                if (div0 || ovf) begin
                    state_nx = MD_DONE;
                    load_res = 1'b1;
                    res_nx   = special_val;
                end else begin
                    state_nx = MD_CALC;
                end
            end
            MD_CALC: begin
                if (cnt == LAST) begin
                    state_nx = MD_FIX;
                end
            end
            MD_FIX: begin
                state_nx = MD_DONE;
                load_res = 1'b1;
                res_nx   = fix_val;
            end
            MD_DONE: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
        if (FLUSH) begin
            state_nx = MD_IDLE;
            load_res = 1'b0;
        end
    end

    // Control registers: state, counter, status flags and the result
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= MD_IDLE;
            cnt          <= '0;
            BUSY         <= 1'b0;
            RESULT_VALID <= 1'b0;
            RESULT       <= '0;
        end else begin
            state        <= state_nx;
            BUSY         <= (state_nx == MD_PREP) || (state_nx == MD_CALC) ||
                            (state_nx == MD_FIX);
            RESULT_VALID <= (state_nx == MD_DONE);
            if (load_res) begin
                RESULT <= res_nx;
            end
            if (state == MD_PREP) begin
                cnt <= '0;
            end else if (state == MD_CALC) begin
                cnt <= cnt + 6'd1;
            end
        end
    end

    // Datapath registers: operand capture, sign/abs preparation, iteration
    always_ff @(posedge CLK) begin
        if (state == MD_IDLE && START) begin
            op <= FUNCT3;
            d1 <= DATA1;
            d2 <= DATA2;
        end
        if (state == MD_PREP) begin
            acc  <= '0;
            q    <= is_div ? abs1 : abs2;
            opnd <= is_div ? abs2 : abs1;
            neg  <= is_rem ? a_neg : (a_neg ^ b_neg);
        end else if (state == MD_CALC) begin
            acc <= acc_nx;
            q   <= q_nx;
        end
    end

    // Stall request: pending accept in IDLE or an op in flight
    always_comb begin
        STALL = ~RESET & (((state == MD_IDLE) & START) | BUSY);
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: divide, signed
// remainder, divide-by-zero, overflow, multiply, flush, reset and
// back-to-back operations.
module tb_muldiv_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [2:0]  FUNCT3 = 3'b000;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        FLUSH = 1'b0;
    logic        BUSY, STALL, RESULT_VALID;
    logic [31:0] RESULT;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 35;
`endif

    muldiv_sequencer dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .FUNCT3       (FUNCT3),
        .DATA1        (DATA1),
        .DATA2        (DATA2),
        .FLUSH        (FLUSH),
        .BUSY         (BUSY),
        .STALL        (STALL),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID)
    );

    always #5 CLK = ~CLK;

    // Issue one op, hold START until RESULT_VALID, scramble operands after
    // capture, and report observed result, stall cycles and valid cycles.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] got, output int stall_cnt, output int vld_cnt);
        got = 'x;
        stall_cnt = 0;
        vld_cnt = 0;
        @(negedge CLK);
        FUNCT3 = f;
        DATA1 = a;
        DATA2 = b;
        START = 1'b1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (STALL) stall_cnt++;
            if (RESULT_VALID) begin
                vld_cnt++;
                got = RESULT;
                START = 1'b0;
            end else if (vld_cnt > 0) begin
                break;
            end
            @(negedge CLK);
            if (c == 0) begin
                DATA1 = ~a;
                DATA2 = b ^ 32'h5A5A_0001;
                FUNCT3 = ~f;
            end
        end
        START = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        START = 1'b1;
        FUNCT3 = 3'b100;
        DATA1 = 32'd5;
        DATA2 = 32'd1;
        repeat (3) @(negedge CLK);
        #1;
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", STALL); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", RESULT_VALID); end
        checks++; if (RESULT !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 00000000", RESULT); end
        START = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_div();
        logic [31:0] got; int st; int vl;
        run_op(3'b100, 32'd100, 32'd7, got, st, vl);
        checks++; if (got !== 32'd14) begin errors++; $display("FAIL div_100_7 result got %h exp %h", got, 32'd14); end
        checks++; if (st !== 35) begin errors++; $display("FAIL div_100_7 stall got %0d exp 35", st); end
        checks++; if (vl !== 1) begin errors++; $display("FAIL div_100_7 valid_cycles got %0d exp 1", vl); end
        run_op(3'b110, 32'd100, 32'd7, got, st, vl);
        checks++; if (got !== 32'd2) begin errors++; $display("FAIL rem_100_7 result got %h exp %h", got, 32'd2); end
        checks++; if (st !== 35) begin errors++; $display("FAIL rem_100_7 stall got %0d exp 35", st); end
    endtask

    task automatic test_signed_rem();
        logic [31:0] got; int st; int vl;
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, got, st, vl);
        checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 result got %h exp ffffffff", got); end
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, got, st, vl);
        checks++; if (got !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 result got %h exp fffffffd", got); end
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, got, st, vl);
        checks++; if (got !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_fff9_2 result got %h exp 7ffffffc", got); end
        checks++; if (vl !== 1) begin errors++; $display("FAIL divu_fff9_2 valid_cycles got %0d exp 1", vl); end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] got; int st; int vl;
        run_op(3'b101, 32'h0000_1234, 32'h0, got, st, vl);
        checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by0 result got %h exp ffffffff", got); end
        checks++; if (st !== 2) begin errors++; $display("FAIL divu_by0 stall got %0d exp 2", st); end
        run_op(3'b111, 32'h0000_1234, 32'h0, got, st, vl);
        checks++; if (got !== 32'h0000_1234) begin errors++; $display("FAIL remu_by0 result got %h exp 00001234", got); end
        checks++; if (st !== 2) begin errors++; $display("FAIL remu_by0 stall got %0d exp 2", st); end
        checks++; if (vl !== 1) begin errors++; $display("FAIL remu_by0 valid_cycles got %0d exp 1", vl); end
    endtask

    task automatic test_overflow();
        logic [31:0] got; int st; int vl;
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, got, st, vl);
        checks++; if (got !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf result got %h exp 80000000", got); end
        checks++; if (st !== 2) begin errors++; $display("FAIL div_ovf stall got %0d exp 2", st); end
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, got, st, vl);
        checks++; if (got !== 32'h0) begin errors++; $display("FAIL rem_ovf result got %h exp 00000000", got); end
        checks++; if (st !== 2) begin errors++; $display("FAIL rem_ovf stall got %0d exp 2", st); end
    endtask

    task automatic test_multiply();
        logic [31:0] got; int st; int vl;
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, got, st, vl);
        checks++; if (got !== 32'h4000_0000) begin errors++; $display("FAIL mulh_min result got %h exp 40000000", got); end
        checks++; if (st !== MUL_STALL) begin errors++; $display("FAIL mulh_min stall got %0d exp %0d", st, MUL_STALL); end
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, st, vl);
        checks++; if (got !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_max result got %h exp fffffffe", got); end
        run_op(3'b000, 32'hFFFF_FFFF, 32'd3, got, st, vl);
        checks++; if (got !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mul_m1_3 result got %h exp fffffffd", got); end
        checks++; if (vl !== 1) begin errors++; $display("FAIL mul_m1_3 valid_cycles got %0d exp 1", vl); end
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, st, vl);
        checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_m1_max result got %h exp ffffffff", got); end
    endtask

    task automatic test_flush();
        int vl;
        logic [31:0] prev;
        prev = RESULT;
        @(negedge CLK);
        FUNCT3 = 3'b100;
        DATA1 = 32'd1000;
        DATA2 = 32'd3;
        START = 1'b1;
        repeat (11) @(negedge CLK);
        #1;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b exp 1", BUSY); end
        FLUSH = 1'b1;
        START = 1'b0;
        @(negedge CLK);
        #1;
        FLUSH = 1'b0;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", BUSY); end
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", STALL); end
        vl = 0;
        for (int c = 0; c < 45; c++) begin
            if (RESULT_VALID) vl++;
            @(negedge CLK);
            #1;
        end
        checks++; if (vl !== 0) begin errors++; $display("FAIL flush_no_valid got %0d exp 0", vl); end
        checks++; if (RESULT !== prev) begin errors++; $display("FAIL flush_result_held got %h exp %h", RESULT, prev); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got; int st; int vl;
        @(negedge CLK);
        FUNCT3 = 3'b101;
        DATA1 = 32'd500;
        DATA2 = 32'd7;
        START = 1'b1;
        repeat (11) @(negedge CLK);
        RESET = 1'b1;
        START = 1'b0;
        #1;
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL rstmid_stall_comb got %b exp 0", STALL); end
        @(negedge CLK);
        #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", BUSY); end
        checks++; if (RESULT !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h exp 00000000", RESULT); end
        checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", RESULT_VALID); end
        RESET = 1'b0;
        run_op(3'b100, 32'd9, 32'd3, got, st, vl);
        checks++; if (got !== 32'd3) begin errors++; $display("FAIL div_9_3 result got %h exp 00000003", got); end
        checks++; if (st !== 35) begin errors++; $display("FAIL div_9_3 stall got %0d exp 35", st); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got; int st; int vl;
        run_op(3'b111, 32'd50, 32'd8, got, st, vl);
        checks++; if (got !== 32'd2) begin errors++; $display("FAIL b2b_remu result got %h exp 00000002", got); end
        run_op(3'b101, 32'd50, 32'd8, got, st, vl);
        checks++; if (got !== 32'd6) begin errors++; $display("FAIL b2b_divu result got %h exp 00000006", got); end
        checks++; if (st !== 35) begin errors++; $display("FAIL b2b_divu stall got %0d exp 35", st); end
        run_op(3'b101, 32'd77, 32'd0, got, st, vl);
        checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_divu0 result got %h exp ffffffff", got); end
    endtask

    initial begin
        test_reset();
        test_div();
        test_signed_rem();
        test_div_by_zero();
        test_overflow();
        test_multiply();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
